fetch_ctrl: RTL and testbench

- Sequences the instruction-fetch stage against a variable-latency instruction memory using a req/ready handshake.
- Drives the PC register load enable, the IF/ID register load enable and flush, and the instruction word into IF/ID.
- Inserts bubbles while a fetch is outstanding and discards in-flight fetches after a branch or jump redirect.
- Sits between the PC/IF-ID registers, the instruction memory port and the hazard/branch logic in ID.

---
 rtl/fetch_ctrl_pkg.sv | 24 ++
 rtl/fetch_ctrl_perf_cnt.sv | 40 ++++
 rtl/fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : State encoding and shared constants for the instruction-fetch
//             controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] C_NOP_INSTR   = 32'h0000_0000;
    localparam int          C_STALL_CNT_W = 32;
    localparam int          C_DISC_CNT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_perf_cnt.sv
// ============================================================================
//  Module   : fetch_perf_cnt
//  Brief    : Free-running stall-cycle and discard-event counters for the
//             fetch controller; both wrap and clear on reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_perf_cnt
    import fetch_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall_inc,
    input  logic                     disc_inc,
    output logic [C_STALL_CNT_W-1:0] stall_cycles,
    output logic [C_DISC_CNT_W-1:0]  discard_cnt
);

    logic [C_STALL_CNT_W-1:0] r_stall_cycles;
    logic [C_DISC_CNT_W-1:0]  r_discard_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_discard_cnt  <= '0;
        end else begin
            if (stall_inc)
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (disc_inc)
                r_discard_cnt  <= r_discard_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign discard_cnt  = r_discard_cnt;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  Module   : fetch_ctrl
//  Brief    : Instruction-fetch sequencer for a variable-latency memory with a
//             req/ready handshake. Optional counters under FETCH_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic              id_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic [31:0]       instr,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       discard_cnt
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [31:0]       r_hold_q;
    logic [ADDR_W-1:0] r_disc_addr_q;
    logic              w_hold_load;
    logic              w_disc_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hold_q      <= '0;
            r_disc_addr_q <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_hold_load)
                r_hold_q <= mem_rdata;
            if (w_disc_load)
                r_disc_addr_q <= pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_hold_load  = 1'b0;
        w_disc_load  = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = pc;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        if_id_flush  = 1'b0;
        instr        = NOP_INSTR;
        busy         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if_id_flush  = 1'b1;
                w_next_state = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                busy    = ~mem_ready;
                if (redirect) begin
                    pc_en       = 1'b1;
                    if_id_flush = 1'b1;
                    // Request still outstanding: remember its address so the
                    // handshake can complete before the new target is fetched.
                    if (!mem_ready) begin
                        w_disc_load  = 1'b1;
                        w_next_state = ST_DISCARD;
                    end
                end else if (mem_ready && !id_stall) begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                    instr    = mem_rdata;
                end else if (mem_ready) begin
                    w_hold_load  = 1'b1;
                    w_next_state = ST_HOLD;
                end else if (!id_stall) begin
                    if_id_flush = 1'b1;
                end
            end

            ST_HOLD: begin
                busy = 1'b1;
                if (redirect) begin
                    pc_en        = 1'b1;
                    if_id_flush  = 1'b1;
                    w_next_state = ST_FETCH;
                end else if (!id_stall) begin
                    pc_en        = 1'b1;
                    if_id_en     = 1'b1;
                    instr        = r_hold_q;
                    w_next_state = ST_FETCH;
                end
            end

            ST_DISCARD: begin
                mem_req     = 1'b1;
                mem_addr    = r_disc_addr_q;
                busy        = 1'b1;
                if_id_flush = ~id_stall;
                if (redirect) begin
                    pc_en       = 1'b1;
                    if_id_flush = 1'b1;
                end
                if (mem_ready)
                    w_next_state = ST_FETCH;
            end

            default: w_next_state = ST_IDLE;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic w_stall_inc;

    assign w_stall_inc = ((r_state == ST_FETCH) && !mem_ready) ||
                         (r_state == ST_DISCARD);

    fetch_perf_cnt u_perf_cnt (
        .clk          (clk),
        .reset        (reset),
        .stall_inc    (w_stall_inc),
        .disc_inc     (w_disc_load),
        .stall_cycles (stall_cycles),
        .discard_cnt  (discard_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Brief    : Directed vector bench for fetch_ctrl (table plus corner-case
//             sequences; counter checks when FETCH_PERF_CNT_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        redirect;
    logic        id_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic [31:0] instr;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [15:0] discard_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.ADDR_W(32), .NOP_INSTR(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .redirect    (redirect),
        .id_stall    (id_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .instr       (instr),
        .busy        (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .discard_cnt (discard_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        redir;
        logic        stall;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_pc_en;
        logic        e_en;
        logic        e_flush;
        logic [31:0] e_instr;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic [31:0] vpc, input logic redir,
        input logic stall, input logic rdy, input logic [31:0] rdata,
        input logic e_req, input logic [31:0] e_addr, input logic e_pc_en,
        input logic e_en, input logic e_flush, input logic [31:0] e_instr,
        input logic e_busy);
        vec_t v;
        v.rst = rst;     v.pc = vpc;       v.redir = redir;
        v.stall = stall; v.rdy = rdy;      v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pc_en = e_pc_en;
        v.e_en = e_en;   v.e_flush = e_flush; v.e_instr = e_instr;
        v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        reset     = v.rst;
        pc        = v.pc;
        redirect  = v.redir;
        id_stall  = v.stall;
        mem_ready = v.rdy;
        mem_rdata = v.rdata;
        #1;
        chk(idx, "mem_req",     32'(mem_req),     32'(v.e_req));
        if (v.e_req)
            chk(idx, "mem_addr", mem_addr, v.e_addr);
        chk(idx, "pc_en",       32'(pc_en),       32'(v.e_pc_en));
        chk(idx, "if_id_en",    32'(if_id_en),    32'(v.e_en));
        chk(idx, "if_id_flush", 32'(if_id_flush), 32'(v.e_flush));
        if (v.e_en || v.e_flush)
            chk(idx, "instr", instr, v.e_instr);
        chk(idx, "busy",        32'(busy),        32'(v.e_busy));
    endtask

    task automatic chk_cnt(input int idx, input logic [31:0] e_stall,
                           input logic [15:0] e_disc);
`ifdef FETCH_PERF_CNT_EN
        chk(idx, "stall_cycles", stall_cycles, e_stall);
        chk(idx, "discard_cnt",  32'(discard_cnt), 32'(e_disc));
`else
        if (e_stall == 32'hFFFF_FFFF && e_disc == 16'hFFFF)
            $display("note: counter expectation sentinel at vec%0d", idx);
`endif
    endtask

    vec_t tbl [14];

    initial begin
        //            rst pc         rd st rdy rdata          req addr       pce en fl instr          busy
        tbl[0]  = mk(1, 32'h00,     0, 0, 1, 32'hDEAD0000, 0, 32'h00,     0,  0, 1, NOP,           0);
        tbl[1]  = mk(0, 32'h00,     0, 0, 1, 32'hDEAD0001, 0, 32'h00,     0,  0, 1, NOP,           0);
        tbl[2]  = mk(0, 32'h00,     0, 0, 1, 32'h00000011, 1, 32'h00,     1,  1, 0, 32'h00000011,  0);
        tbl[3]  = mk(0, 32'h04,     0, 0, 1, 32'h00000022, 1, 32'h04,     1,  1, 0, 32'h00000022,  0);
        tbl[4]  = mk(0, 32'h08,     0, 0, 1, 32'h00000033, 1, 32'h08,     1,  1, 0, 32'h00000033,  0);
        tbl[5]  = mk(0, 32'h0C,     0, 0, 1, 32'h00000044, 1, 32'h0C,     1,  1, 0, 32'h00000044,  0);
        tbl[6]  = mk(0, 32'h10,     0, 0, 0, 32'h0,        1, 32'h10,     0,  0, 1, NOP,           1);
        tbl[7]  = mk(0, 32'h10,     0, 0, 0, 32'h0,        1, 32'h10,     0,  0, 1, NOP,           1);
        tbl[8]  = mk(0, 32'h10,     0, 0, 1, 32'h8C220004, 1, 32'h10,     1,  1, 0, 32'h8C220004,  0);
        tbl[9]  = mk(0, 32'h14,     0, 1, 0, 32'h0,        1, 32'h14,     0,  0, 0, NOP,           1);
        tbl[10] = mk(0, 32'h14,     1, 0, 1, 32'h00000BAD, 1, 32'h14,     1,  0, 1, NOP,           0);
        tbl[11] = mk(0, 32'h80,     0, 0, 1, 32'h00000055, 1, 32'h80,     1,  1, 0, 32'h00000055,  0);
        tbl[12] = mk(0, 32'h84,     1, 1, 1, 32'h00000BAD, 1, 32'h84,     1,  0, 1, NOP,           0);
        tbl[13] = mk(0, 32'h90,     0, 0, 1, 32'h00000066, 1, 32'h90,     1,  1, 0, 32'h00000066,  0);

        reset = 1'b1; pc = '0; redirect = 1'b0; id_stall = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            apply_vec(tbl[i], i);
            if (i == 0)
                chk_cnt(i, 32'd0, 16'd0);
        end

        // Ready while ID stalls: capture into HOLD, replay on release.
        apply_vec(mk(0, 32'h94, 0, 1, 1, 32'hA1B2C3D4, 1, 32'h94, 0, 0, 0, NOP, 0), 100);
        apply_vec(mk(0, 32'h94, 0, 1, 0, 32'h0,        0, 32'h94, 0, 0, 0, NOP, 1), 101);
        apply_vec(mk(0, 32'h94, 0, 1, 0, 32'h0,        0, 32'h94, 0, 0, 0, NOP, 1), 102);
        apply_vec(mk(0, 32'h94, 0, 0, 0, 32'h0,        0, 32'h94, 1, 1, 0, 32'hA1B2C3D4, 1), 103);
        apply_vec(mk(0, 32'h98, 0, 0, 1, 32'h00000077, 1, 32'h98, 1, 1, 0, 32'h00000077, 0), 104);

        // Redirect while in HOLD drops the held word.
        apply_vec(mk(0, 32'h9C, 0, 1, 1, 32'h000000EE, 1, 32'h9C, 0, 0, 0, NOP, 0), 105);
        apply_vec(mk(0, 32'h9C, 1, 1, 0, 32'h0,        0, 32'h9C, 1, 0, 1, NOP, 1), 106);
        apply_vec(mk(0, 32'hC0, 0, 0, 1, 32'h00000088, 1, 32'hC0, 1, 1, 0, 32'h00000088, 0), 107);

        // Reset from FETCH so counters start from zero for the discard run.
        apply_vec(mk(1, 32'hC4, 0, 0, 0, 32'h0,        1, 32'hC4, 0, 0, 1, NOP, 1), 108);
        apply_vec(mk(0, 32'hC4, 0, 0, 0, 32'h0,        0, 32'hC4, 0, 0, 1, NOP, 0), 109);
        chk_cnt(109, 32'd0, 16'd0);

        // Redirect to 0x40 while the 0x14 request is outstanding.
        apply_vec(mk(0, 32'h14, 0, 0, 0, 32'h0,        1, 32'h14, 0, 0, 1, NOP, 1), 110);
        apply_vec(mk(0, 32'h14, 1, 0, 0, 32'h0,        1, 32'h14, 1, 0, 1, NOP, 1), 111);
        apply_vec(mk(0, 32'h40, 0, 0, 0, 32'h0,        1, 32'h14, 0, 0, 1, NOP, 1), 112);
        chk_cnt(112, 32'd2, 16'd1);
        apply_vec(mk(0, 32'h40, 0, 0, 1, 32'h00000BAD, 1, 32'h14, 0, 0, 1, NOP, 1), 113);
        apply_vec(mk(0, 32'h40, 0, 0, 0, 32'h0,        1, 32'h40, 0, 0, 1, NOP, 1), 114);
        chk_cnt(114, 32'd4, 16'd1);

        // Re-enter DISCARD, take a further redirect, then reset mid-request.
        apply_vec(mk(0, 32'h40, 1, 0, 0, 32'h0,        1, 32'h40, 1, 0, 1, NOP, 1), 115);
        apply_vec(mk(0, 32'h50, 1, 1, 0, 32'h0,        1, 32'h40, 1, 0, 1, NOP, 1), 116);
        chk_cnt(116, 32'd6, 16'd2);
        apply_vec(mk(1, 32'h60, 0, 1, 0, 32'h0,        1, 32'h40, 0, 0, 0, NOP, 1), 117);
        apply_vec(mk(0, 32'h60, 0, 0, 1, 32'h00000BAD, 0, 32'h60, 0, 0, 1, NOP, 0), 118);
        chk_cnt(118, 32'd0, 16'd0);
        apply_vec(mk(0, 32'h60, 0, 0, 1, 32'h00000099, 1, 32'h60, 1, 1, 0, 32'h00000099, 0), 119);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
